cpu_execute_unit: RTL and testbench

Parametrised execute stage that replaces the fixed single-op ALU stage between decode/register-read and commit. It resolves operand forwarding, executes single-cycle ALU/shift ops and an iterative multi-cycle multiply, and produces condition flags from the result it delivers. It uses valid/ready handshakes on both sides, so the upstream stage is stalled while a multiply is in flight or commit back-pressures.

---
 rtl/cpu_exec_pkg.sv | 61 ++++++
 rtl/cpu_execute_unit_if.sv | 53 +++++
 rtl/cpu_exec_multiplier.sv | 72 +++++++
 rtl/cpu_execute_unit.sv | 186 ++++++++++++++++++
 tb/tb_cpu_execute_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_exec_pkg.sv
// -----------------------------------------------------------------------------
// cpu_exec_pkg
// Shared types for the execute stage: ALU op codes, FSM state encoding, the
// condition-flag bundle and the flag calculation used for every result that
// leaves the unit.
// -----------------------------------------------------------------------------
package cpu_exec_pkg;

    localparam int BYPASS_W = 2;    // bit1: commit value, bit0: writeback value

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_MOV = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic overflow;
    } flags_t;

    // Carry/overflow only mean something for ADD and SUB. For SUB the caller
    // passes the carry-out of A + ~B + 1, which is the no-borrow bit, and the
    // msb of the original (non-inverted) B.
    function automatic flags_t calc_flags(input alu_op_t op,
                                          input logic    res_zero,
                                          input logic    res_msb,
                                          input logic    carry_out,
                                          input logic    a_msb,
                                          input logic    b_msb);
        flags_t f;
        f.zero     = res_zero;
        f.neg      = res_msb;
        f.carry    = 1'b0;
        f.overflow = 1'b0;
        if (op == OP_ADD) begin
            f.carry    = carry_out;
            f.overflow = (a_msb == b_msb) && (res_msb != a_msb);
        end else if (op == OP_SUB) begin
            f.carry    = carry_out;
            f.overflow = (a_msb != b_msb) && (res_msb != a_msb);
        end
        return f;
    endfunction

endpackage

// File: rtl/cpu_execute_unit_if.sv
// -----------------------------------------------------------------------------
// cpu_execute_unit_if
// Upstream (decode/register-read) and downstream (commit) handshake bundle of
// the execute stage.
//   master : driven by the surrounding pipeline (op, operands, out_ready)
//   slave  : the execute unit (in_ready, results, flags, busy)
// -----------------------------------------------------------------------------
interface cpu_execute_unit_if #(
    parameter int WIDTH        = 32,
    parameter int REG_ID_WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_alu_op;
    logic [WIDTH-1:0]        in_ra_data;
    logic [WIDTH-1:0]        in_rb_data;
    logic [WIDTH-1:0]        in_offset;
    logic                    in_use_offset;
    logic [1:0]              in_ra_bypass;
    logic [1:0]              in_rb_bypass;
    logic [WIDTH-1:0]        fw_commit_value;
    logic [WIDTH-1:0]        fw_wb_value;
    logic [REG_ID_WIDTH-1:0] in_reg_dest;
    logic                    in_writeback;

    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_result;
    logic [WIDTH-1:0]        out_rb_data;
    logic [REG_ID_WIDTH-1:0] out_reg_dest;
    logic                    out_writeback;
    logic                    out_zero;
    logic                    out_neg;
    logic                    out_carry;
    logic                    out_overflow;
    logic                    busy;

    modport master (
        output in_valid, in_alu_op, in_ra_data, in_rb_data, in_offset,
               in_use_offset, in_ra_bypass, in_rb_bypass, fw_commit_value,
               fw_wb_value, in_reg_dest, in_writeback, out_ready,
        input  in_ready, out_valid, out_result, out_rb_data, out_reg_dest,
               out_writeback, out_zero, out_neg, out_carry, out_overflow, busy
    );

    modport slave (
        input  in_valid, in_alu_op, in_ra_data, in_rb_data, in_offset,
               in_use_offset, in_ra_bypass, in_rb_bypass, fw_commit_value,
               fw_wb_value, in_reg_dest, in_writeback, out_ready,
        output in_ready, out_valid, out_result, out_rb_data, out_reg_dest,
               out_writeback, out_zero, out_neg, out_carry, out_overflow, busy
    );
endinterface

// File: rtl/cpu_exec_multiplier.sv
// -----------------------------------------------------------------------------
// cpu_exec_multiplier
// Iterative shift-add multiplier producing the low WIDTH bits of A*B,
// retiring MUL_STEP multiplier bits per enabled cycle.
//   clock, reset : clock, synchronous active-low reset
//   i_start      : latch i_a/i_b, clear accumulator and counter
//   i_step       : perform one iteration
//   o_last       : the current iteration is the final one
//   o_done       : all iterations complete, o_product valid
//   o_product    : accumulated low product
// -----------------------------------------------------------------------------
module cpu_exec_multiplier #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [WIDTH-1:0] r_a;      // multiplicand, pre-shifted to current weight
    logic [WIDTH-1:0] r_b;      // multiplier, consumed from the lsb
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_pp [MUL_STEP];
    logic [WIDTH-1:0] w_step_sum;

    // One partial product per multiplier bit retired this cycle.
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
        assign w_pp[gi] = r_b[gi] ? (r_a << gi) : '0;
    end

    always_comb begin
        w_step_sum = r_acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            w_step_sum = w_step_sum + w_pp[j];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_step_sum;
            r_a   <= r_a << MUL_STEP;
            r_b   <= r_b >> MUL_STEP;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last    = (r_cnt == CNT_W'(STEPS - 1));
    assign o_done    = (r_cnt == CNT_W'(STEPS));
    assign o_product = r_acc;

endmodule

// File: rtl/cpu_execute_unit.sv
// -----------------------------------------------------------------------------
// cpu_execute_unit
// Execute stage: operand forwarding, single-cycle ALU/shift ops, iterative
// multiply, condition flags, and a registered valid/ready output.
//   clock : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of cpu_execute_unit_if (upstream op + commit result)
// -----------------------------------------------------------------------------
module cpu_execute_unit
    import cpu_exec_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int REG_ID_WIDTH = 4,
    parameter int MUL_STEP     = 1
) (
    input  logic             clock,
    input  logic             reset,
    cpu_execute_unit_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    exec_state_t             r_state, w_state_next;

    logic [WIDTH-1:0]        w_a, w_rb, w_b, w_b_addend, w_alu_res, w_product;
    logic [WIDTH:0]          w_sum;
    logic [SHAMT_W-1:0]      w_shamt;
    logic                    w_is_sub, w_out_free, w_in_ready, w_accept;
    logic                    w_mul_start, w_mul_step, w_mul_last, w_mul_done;
    logic                    w_load_alu, w_load_mul;
    alu_op_t                 w_op;
    flags_t                  w_alu_flags, w_mul_flags;

    logic                    r_out_valid, r_out_wb, r_mul_wb;
    logic [WIDTH-1:0]        r_out_result, r_out_rb, r_mul_rb;
    logic [REG_ID_WIDTH-1:0] r_out_dest, r_mul_dest;
    flags_t                  r_flags;

    // Commit value has priority over writeback value over register data.
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [BYPASS_W-1:0] sel,
                                                 input logic [WIDTH-1:0]    reg_v,
                                                 input logic [WIDTH-1:0]    commit_v,
                                                 input logic [WIDTH-1:0]    wb_v);
        if (sel[1])      return commit_v;
        else if (sel[0]) return wb_v;
        else             return reg_v;
    endfunction

    assign w_op  = alu_op_t'(bus.in_alu_op);
    assign w_a   = fwd_mux(bus.in_ra_bypass, bus.in_ra_data, bus.fw_commit_value, bus.fw_wb_value);
    assign w_rb  = fwd_mux(bus.in_rb_bypass, bus.in_rb_data, bus.fw_commit_value, bus.fw_wb_value);
    assign w_b   = bus.in_use_offset ? bus.in_offset : w_rb;

    // Shared adder: SUB is A + ~B + 1 so the carry-out is the no-borrow bit.
    assign w_is_sub   = (w_op == OP_SUB);
    assign w_b_addend = w_is_sub ? ~w_b : w_b;
    assign w_sum      = {1'b0, w_a} + {1'b0, w_b_addend} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_shamt    = w_b[SHAMT_W-1:0];

    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_ADD, OP_SUB: w_alu_res = w_sum[WIDTH-1:0];
            OP_AND:         w_alu_res = w_a & w_b;
            OP_OR:          w_alu_res = w_a | w_b;
            OP_XOR:         w_alu_res = w_a ^ w_b;
            OP_SLL:         w_alu_res = w_a << w_shamt;
            OP_SRL:         w_alu_res = w_a >> w_shamt;
            OP_SRA:         w_alu_res = $unsigned($signed(w_a) >>> w_shamt);
            OP_MOV:         w_alu_res = w_b;
            default:        w_alu_res = '0;   // MUL goes via the multiplier; 10-15 yield 0
        endcase
    end

    assign w_alu_flags = calc_flags(w_op, (w_alu_res == '0), w_alu_res[WIDTH-1],
                                    w_sum[WIDTH], w_a[WIDTH-1], w_b[WIDTH-1]);
    assign w_mul_flags = calc_flags(OP_MUL, (w_product == '0), w_product[WIDTH-1],
                                    1'b0, 1'b0, 1'b0);

    cpu_exec_multiplier #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_step    (w_mul_step),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_last    (w_mul_last),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // The output register can take new data if empty or being drained now.
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        w_load_alu   = 1'b0;
        w_load_mul   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_load_alu   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_out_free && w_mul_done) begin
                    w_load_mul   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mul_rb   <= '0;
            r_mul_dest <= '0;
            r_mul_wb   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_mul_start) begin
                r_mul_rb   <= w_rb;
                r_mul_dest <= bus.in_reg_dest;
                r_mul_wb   <= bus.in_writeback;
            end
        end
    end

    // A load in the same cycle as a drain keeps out_valid high with new data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rb     <= '0;
            r_out_dest   <= '0;
            r_out_wb     <= 1'b0;
            r_flags      <= '0;
        end else if (w_load_alu) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_alu_res;
            r_out_rb     <= w_rb;
            r_out_dest   <= bus.in_reg_dest;
            r_out_wb     <= bus.in_writeback;
            r_flags      <= w_alu_flags;
        end else if (w_load_mul) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_product;
            r_out_rb     <= r_mul_rb;
            r_out_dest   <= r_mul_dest;
            r_out_wb     <= r_mul_wb;
            r_flags      <= w_mul_flags;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_out_result;
    assign bus.out_rb_data   = r_out_rb;
    assign bus.out_reg_dest  = r_out_dest;
    assign bus.out_writeback = r_out_wb;
    assign bus.out_zero      = r_flags.zero;
    assign bus.out_neg       = r_flags.neg;
    assign bus.out_carry     = r_flags.carry;
    assign bus.out_overflow  = r_flags.overflow;

endmodule

// File: tb/tb_cpu_execute_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_execute_unit
// Scoreboard bench: each accepted op pushes its expected response computed by
// an arithmetic reference model; a monitor pops and compares on every output
// handshake. Directed cases cover latency, back-pressure, shifts and reset.
// -----------------------------------------------------------------------------
module tb_cpu_execute_unit;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cpu_execute_unit_if #(.WIDTH(W), .REG_ID_WIDTH(4)) bus  ();
    cpu_execute_unit_if #(.WIDTH(W), .REG_ID_WIDTH(4)) bus4 ();

    cpu_execute_unit #(.WIDTH(W), .REG_ID_WIDTH(4), .MUL_STEP(1)) dut (
        .clock (clock), .reset (reset), .bus (bus)
    );
    cpu_execute_unit #(.WIDTH(W), .REG_ID_WIDTH(4), .MUL_STEP(4)) dut4 (
        .clock (clock), .reset (reset), .bus (bus4)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] rb;
        logic [3:0]  dest;
        logic        wb;
        logic [3:0]  flg;   // {zero, neg, carry, overflow}
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   done_rnd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] c, input logic [31:0] wv);
        return sel[1] ? c : (sel[0] ? wv : r);
    endfunction

    // Reference model from the arithmetic definition of each op.
    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] rb, input logic [3:0] dest, input logic wb);
        exp_t e;
        longint sa, sbv, r64;
        longint unsigned ua, ub;
        logic c, v;
        int sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        sh  = int'(b % 32);
        c = 1'b0; v = 1'b0;
        case (op)
            0: begin e.res = a + b; c = (ua + ub) >= 64'h1_0000_0000; r64 = sa + sbv; v = (r64 > SMAX) || (r64 < SMIN); end
            1: begin e.res = a - b; c = (a >= b); r64 = sa - sbv; v = (r64 > SMAX) || (r64 < SMIN); end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: e.res = a << sh;
            6: e.res = a >> sh;
            7: e.res = 32'(sa >>> sh);
            8: e.res = 32'(ua * ub);
            9: e.res = b;
            default: e.res = 32'h0;
        endcase
        e.rb   = rb;
        e.dest = dest;
        e.wb   = wb;
        e.flg  = {(e.res == 32'h0), e.res[31], c, v};
        return e;
    endfunction

    // Entered just after a rising edge; returns just after the accept edge.
    task automatic issue(input int op, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] off, input logic uo,
                         input logic [1:0] rab, input logic [1:0] rbb,
                         input logic [31:0] fc, input logic [31:0] fwv,
                         input logic [3:0] dest, input logic wbk);
        logic [31:0] a, bb, rbv;
        int waitc;
        waitc = 0;
        bus.in_alu_op       = 4'(op);
        bus.in_ra_data      = ra;
        bus.in_rb_data      = rb;
        bus.in_offset       = off;
        bus.in_use_offset   = uo;
        bus.in_ra_bypass    = rab;
        bus.in_rb_bypass    = rbb;
        bus.fw_commit_value = fc;
        bus.fw_wb_value     = fwv;
        bus.in_reg_dest     = dest;
        bus.in_writeback    = wbk;
        bus.in_valid        = 1'b1;
        rbv = fwd(rbb, rb, fc, fwv);
        a   = fwd(rab, ra, fc, fwv);
        bb  = uo ? off : rbv;
        @(negedge clock);
        while (!bus.in_ready) begin
            waitc++;
            if (waitc > 300) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: in_ready got 0 for %0d cycles, want 1", waitc);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        sb.push_back(model(op, a, bb, rbv, dest, wbk));
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rnd_issue();
        int op;
        op = $urandom_range(0, 15);
        if (op == 8 && $urandom_range(0, 3) != 0) op = 0;
        issue(op, rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // Monitor: compares on every output handshake, and checks held data is stable.
    initial begin : monitor
        exp_t e;
        logic hold_v;
        logic [31:0] hold_res, hold_rb;
        hold_v = 1'b0; hold_res = '0; hold_rb = '0;
        forever begin
            @(negedge clock);
            if (hold_v && reset) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_result", bus.out_result, hold_res);
                chk("hold_rb", bus.out_rb_data, hold_rb);
            end
            hold_v   = bus.out_valid && !bus.out_ready;
            hold_res = bus.out_result;
            hold_rb  = bus.out_rb_data;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got result %h, want no output", bus.out_result);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    $display("out %0d: result=%h rb=%h dest=%0d wb=%b znco=%b",
                             n_out, bus.out_result, bus.out_rb_data, bus.out_reg_dest,
                             bus.out_writeback,
                             {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_overflow});
                    chk("result", bus.out_result, e.res);
                    chk("rb_data", bus.out_rb_data, e.rb);
                    chk("sideband", {bus.out_reg_dest, bus.out_writeback}, {e.dest, e.wb});
                    chk("flags", {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_overflow}, e.flg);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat, k;
        logic ok_busy;
        logic [31:0] first;

        bus.in_valid = 0; bus.in_alu_op = 0; bus.in_ra_data = 0; bus.in_rb_data = 0;
        bus.in_offset = 0; bus.in_use_offset = 0; bus.in_ra_bypass = 0; bus.in_rb_bypass = 0;
        bus.fw_commit_value = 0; bus.fw_wb_value = 0; bus.in_reg_dest = 0;
        bus.in_writeback = 0; bus.out_ready = 1;
        bus4.in_valid = 0; bus4.in_alu_op = 0; bus4.in_ra_data = 0; bus4.in_rb_data = 0;
        bus4.in_offset = 0; bus4.in_use_offset = 0; bus4.in_ra_bypass = 0; bus4.in_rb_bypass = 0;
        bus4.fw_commit_value = 0; bus4.fw_wb_value = 0; bus4.in_reg_dest = 0;
        bus4.in_writeback = 0; bus4.out_ready = 1;

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // ADD overflow into the sign bit, one-cycle latency.
        issue(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 4'd1, 1'b1);
        @(negedge clock);
        chk("add_valid", bus.out_valid, 1);
        chk("add_result", bus.out_result, 32'h8000_0000);
        chk("add_znco", {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_overflow}, 4'b0101);
        @(posedge clock); #1;

        // SUB with rb forwarded from commit, then with immediate.
        issue(1, 32'd5, 32'd9, 0, 0, 2'b00, 2'b10, 32'd5, 32'd77, 4'd2, 1'b1);
        @(negedge clock);
        chk("sub_result", bus.out_result, 32'h0);
        chk("sub_zc", {bus.out_zero, bus.out_carry}, 2'b11);
        @(posedge clock); #1;
        issue(1, 32'd5, 32'd9, 32'd5, 1, 2'b00, 2'b00, 32'd7, 32'd0, 4'd3, 1'b0);
        @(negedge clock);
        chk("st_rb_data", bus.out_rb_data, 32'd9);
        chk("st_zero", bus.out_zero, 1);
        @(posedge clock); #1;

        // MUL latency and stall behaviour.
        issue(8, 32'd1234, 32'd5678, 0, 0, 2'b00, 2'b00, 0, 0, 4'd4, 1'b1);
        lat = 0; ok_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.out_valid) break;
            if (bus.in_ready || !bus.busy) ok_busy = 1'b0;
            lat++;
        end
        chk("mul_latency", lat, 33);
        chk("mul_stall", ok_busy, 1);
        chk("mul_result", bus.out_result, 32'd7006652);
        @(posedge clock); #1;

        // Same multiply with four bits per cycle.
        bus4.in_alu_op = 4'd8; bus4.in_ra_data = 32'd1234; bus4.in_rb_data = 32'd5678;
        bus4.in_valid = 1'b1;
        @(negedge clock);
        chk("mul4_in_ready", bus4.in_ready, 1);
        @(posedge clock); #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus4.out_valid) break;
            lat++;
        end
        chk("mul4_latency", lat, 9);
        chk("mul4_result", bus4.out_result, 32'd7006652);
        @(posedge clock); #1;

        // Back-pressure: three ADDs while commit stalls for four cycles.
        bus.out_ready = 1'b0;
        fork
            begin
                issue(0, 32'd10, 32'd1, 0, 0, 2'b00, 2'b00, 0, 0, 4'd5, 1'b1);
                issue(0, 32'd20, 32'd2, 0, 0, 2'b00, 2'b00, 0, 0, 4'd6, 1'b1);
                issue(0, 32'd30, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0, 4'd7, 1'b1);
            end
            begin
                k = 0;
                @(negedge clock);
                while (!bus.out_valid && k < 50) begin @(negedge clock); k++; end
                first = bus.out_result;
                chk("bp_first", first, 32'd11);
                repeat (4) begin
                    chk("bp_in_ready", bus.in_ready, 0);
                    chk("bp_hold", bus.out_result, 32'd11);
                    @(negedge clock);
                end
                @(posedge clock); #1;
                bus.out_ready = 1'b1;
            end
        join

        // Shift boundaries.
        issue(7, 32'h8000_0000, 32'd31, 0, 0, 2'b00, 2'b00, 0, 0, 4'd8, 1'b0);
        issue(5, 32'h1, 32'd35, 0, 0, 2'b00, 2'b00, 0, 0, 4'd9, 1'b0);

        // Randomised traffic with random commit back-pressure.
        fork
            begin
                for (int i = 0; i < 300; i++) rnd_issue();
                done_rnd = 1'b1;
            end
            begin
                while (!done_rnd) begin
                    @(posedge clock); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 500) begin @(negedge clock); k++; end
        chk("drain_empty", sb.size(), 0);
        @(posedge clock); #1;

        // Reset in the middle of a multiply discards it.
        issue(0, 32'd3, 32'd4, 0, 0, 2'b00, 2'b00, 0, 0, 4'd10, 1'b1);
        issue(8, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 2'b00, 2'b00, 0, 0, 4'd11, 1'b1);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_data", {bus.out_result, bus.out_rb_data}, 64'h0);
        chk("mrst_side", {bus.out_reg_dest, bus.out_writeback, bus.out_zero, bus.out_neg,
                          bus.out_carry, bus.out_overflow}, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_busy", bus.busy, 0);
        @(posedge clock); #1;

        issue(9, 32'h0, 32'hA5A5_0001, 0, 0, 2'b00, 2'b00, 0, 0, 4'd12, 1'b1);
        k = 0;
        while (sb.size() != 0 && k < 100) begin @(negedge clock); k++; end
        chk("final_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
